dmem_ctrl: RTL

Wait-state data-memory responder for the RISC-V pipeline's data port. It accepts one load or store request at a time over a valid/ready handshake and holds it for a programmable number of wait cycles. It then performs a word-addressed RAM access and returns a response on a second valid/ready handshake. It sits between the core's memory stage and backing storage, replacing the zero-latency data memory when stall behaviour must be exercised.

---
 rtl/dmem_ctrl_if.sv | 27 ++
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bus between the core memory stage and the
// wait-state data-memory responder. Request and response each use a
// valid/ready handshake.
interface dmem_ctrl_if;
  // request channel (core -> responder)
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  // response channel (responder -> core)
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: wait-state data-memory responder.
// Accepts one load/store at a time, holds it WAIT cycles, then performs a
// word-addressed RAM access and presents the result until the core takes it.
// Stores return the word value that was in memory before the write.
// Misaligned or out-of-range accesses respond with rsp_err=1, rdata=0, and
// never write.
// Optional feature: define DMEM_CTRL_BE_EN to honour per-byte store enables;
// without it req_be is ignored and every good store writes the full word.
module dmem_ctrl #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_ctrl_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        we_q,    we_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;

  // backing store: deliberately not reset, contents survive reset
  logic [31:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             acc_err;
  logic             access;
  logic             mem_we;
  logic [31:0]      mem_old;
  logic [31:0]      mem_new;
  logic             lanes_any;

  // word index and address checks work on the captured request only
  assign idx     = addr_q[IDX_W+1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) ||
                   ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign access  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign mem_old = mem[idx];

`ifdef DMEM_CTRL_BE_EN
  logic [3:0] be_q, be_d;

  // merge enabled store lanes over the current word
  always_comb begin
    mem_new = mem_old;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) mem_new[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // an all-zero byte mask still responds but leaves the word untouched
  assign lanes_any = |be_q;
`else
  // byte enables have no effect in this build
  logic unused_be;
  assign unused_be = ^bus.req_be;
  assign mem_new   = wdata_q;
  assign lanes_any = 1'b1;
`endif

  assign mem_we = access && we_q && !acc_err && lanes_any;

  // RAM write port, active only on the access edge of a good store
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= mem_new;
  end

  // handshake outputs decode registered state only; req_ready is held low
  // while reset is asserted so nothing is taken during reset
  assign bus.req_ready = (state_q == ST_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // state and request/response registers; reset drops any in-flight request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
`ifdef DMEM_CTRL_BE_EN
      be_q    <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_CTRL_BE_EN
      be_q    <= be_d;
`endif
    end
  end

  // next-state: accept in IDLE, count down in WAIT, hold response in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef DMEM_CTRL_BE_EN
    be_d    = be_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef DMEM_CTRL_BE_EN
          be_d    = bus.req_be;
`endif
          cnt_d   = 4'(WAIT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // access edge: capture pre-write word (or zero on error)
          rdata_d = acc_err ? 32'd0 : mem_old;
          err_d   = acc_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
